// File: rtl/cache_system.sv
// German cache-coherence protocol (3 clients) as a rule-firing state machine.
// Each cycle io_en_a names one guarded rule; it fires only when its guard holds.
module cache_system (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] io_en_a
);

    localparam int unsigned N_CLIENTS = 3;
    localparam int unsigned CLI_W     = 2;

    typedef enum logic [1:0] {
        CACHE_I = 2'd0,
        CACHE_S = 2'd1,
        CACHE_E = 2'd2
    } cache_t;

    typedef enum logic [2:0] {
        MSG_EMPTY   = 3'd0,
        MSG_REQS    = 3'd1,
        MSG_REQE    = 3'd2,
        MSG_INV     = 3'd3,
        MSG_INVACK  = 3'd4,
        MSG_GNTS    = 3'd5,
        MSG_GNTE    = 3'd6
    } msg_t;

    // Rule groups; each covers three consecutive rule indices (one per client)
    typedef enum logic [4:0] {
        G_SEND_REQS    = 5'd0,
        G_SEND_REQE    = 5'd1,
        G_RECV_REQ     = 5'd2,
        G_SEND_INV     = 5'd3,
        G_SEND_INVACK  = 5'd4,
        G_RECV_INVACK  = 5'd5,
        G_SEND_GNTS    = 5'd6,
        G_SEND_GNTE    = 5'd7,
        G_RECV_GNTS    = 5'd8,
        G_RECV_GNTE    = 5'd9
    } group_t;

    cache_t                 cache_reg        [N_CLIENTS];
    msg_t                   channel1_reg     [N_CLIENTS];
    msg_t                   channel2_4_reg   [N_CLIENTS];
    msg_t                   channel3_reg     [N_CLIENTS];
    logic [N_CLIENTS-1:0]   home_sharer_list_reg;
    logic [N_CLIENTS-1:0]   home_invalidate_list_reg;
    msg_t                   home_current_command_reg;
    logic [CLI_W-1:0]       home_current_client_reg;
    logic                   home_exclusive_granted_reg;

    cache_t                 cache_nxt        [N_CLIENTS];
    msg_t                   channel1_nxt     [N_CLIENTS];
    msg_t                   channel2_4_nxt   [N_CLIENTS];
    msg_t                   channel3_nxt     [N_CLIENTS];
    logic [N_CLIENTS-1:0]   sharer_nxt;
    logic [N_CLIENTS-1:0]   invalidate_nxt;
    msg_t                   command_nxt;
    logic [CLI_W-1:0]       client_nxt;
    logic                   exclusive_nxt;

    logic [4:0]             grp_c;
    logic [CLI_W-1:0]       cli_c;
    logic                   coherent_c;

    assign grp_c = io_en_a / 5'd3;
    assign cli_c = CLI_W'(io_en_a % 5'd3);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                cache_reg[i]      <= CACHE_I;
                channel1_reg[i]   <= MSG_EMPTY;
                channel2_4_reg[i] <= MSG_EMPTY;
                channel3_reg[i]   <= MSG_EMPTY;
            end
            home_sharer_list_reg       <= '0;
            home_invalidate_list_reg   <= '0;
            home_current_command_reg   <= MSG_EMPTY;
            home_current_client_reg    <= '0;
            home_exclusive_granted_reg <= 1'b0;
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                cache_reg[i]      <= cache_nxt[i];
                channel1_reg[i]   <= channel1_nxt[i];
                channel2_4_reg[i] <= channel2_4_nxt[i];
                channel3_reg[i]   <= channel3_nxt[i];
            end
            home_sharer_list_reg       <= sharer_nxt;
            home_invalidate_list_reg   <= invalidate_nxt;
            home_current_command_reg   <= command_nxt;
            home_current_client_reg    <= client_nxt;
            home_exclusive_granted_reg <= exclusive_nxt;
        end
    end

    // Rule firing: everything holds unless the selected rule's guard is true
    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            cache_nxt[i]      = cache_reg[i];
            channel1_nxt[i]   = channel1_reg[i];
            channel2_4_nxt[i] = channel2_4_reg[i];
            channel3_nxt[i]   = channel3_reg[i];
        end
        sharer_nxt     = home_sharer_list_reg;
        invalidate_nxt = home_invalidate_list_reg;
        command_nxt    = home_current_command_reg;
        client_nxt     = home_current_client_reg;
        exclusive_nxt  = home_exclusive_granted_reg;

        case (grp_c)
            G_SEND_REQS: begin
                if (channel1_reg[cli_c] == MSG_EMPTY && cache_reg[cli_c] == CACHE_I)
                    channel1_nxt[cli_c] = MSG_REQS;
            end
            G_SEND_REQE: begin
                if (channel1_reg[cli_c] == MSG_EMPTY &&
                    (cache_reg[cli_c] == CACHE_I || cache_reg[cli_c] == CACHE_S))
                    channel1_nxt[cli_c] = MSG_REQE;
            end
            G_RECV_REQ: begin
                if (home_current_command_reg == MSG_EMPTY && channel1_reg[cli_c] != MSG_EMPTY) begin
                    command_nxt         = channel1_reg[cli_c];
                    client_nxt          = cli_c;
                    channel1_nxt[cli_c] = MSG_EMPTY;
                    invalidate_nxt      = home_sharer_list_reg;
                end
            end
            G_SEND_INV: begin
                if (channel2_4_reg[cli_c] == MSG_EMPTY && home_invalidate_list_reg[cli_c] &&
                    (home_current_command_reg == MSG_REQE ||
                     (home_current_command_reg == MSG_REQS && home_exclusive_granted_reg))) begin
                    channel2_4_nxt[cli_c] = MSG_INV;
                    invalidate_nxt[cli_c] = 1'b0;
                end
            end
            G_SEND_INVACK: begin
                if (channel2_4_reg[cli_c] == MSG_INV && channel3_reg[cli_c] == MSG_EMPTY) begin
                    channel2_4_nxt[cli_c] = MSG_EMPTY;
                    channel3_nxt[cli_c]   = MSG_INVACK;
                    cache_nxt[cli_c]      = CACHE_I;
                end
            end
            G_RECV_INVACK: begin
                if (channel3_reg[cli_c] == MSG_INVACK && home_current_command_reg != MSG_EMPTY) begin
                    channel3_nxt[cli_c] = MSG_EMPTY;
                    sharer_nxt[cli_c]   = 1'b0;
                    exclusive_nxt       = 1'b0;
                end
            end
            G_SEND_GNTS: begin
                if (home_current_command_reg == MSG_REQS && home_current_client_reg == cli_c &&
                    !home_exclusive_granted_reg && channel2_4_reg[cli_c] == MSG_EMPTY) begin
                    channel2_4_nxt[cli_c] = MSG_GNTS;
                    sharer_nxt[cli_c]     = 1'b1;
                    command_nxt           = MSG_EMPTY;
                end
            end
            G_SEND_GNTE: begin
                if (home_current_command_reg == MSG_REQE && home_current_client_reg == cli_c &&
                    !home_exclusive_granted_reg && home_sharer_list_reg == '0 &&
                    channel2_4_reg[cli_c] == MSG_EMPTY) begin
                    channel2_4_nxt[cli_c] = MSG_GNTE;
                    sharer_nxt[cli_c]     = 1'b1;
                    exclusive_nxt         = 1'b1;
                    command_nxt           = MSG_EMPTY;
                end
            end
            G_RECV_GNTS: begin
                if (channel2_4_reg[cli_c] == MSG_GNTS) begin
                    cache_nxt[cli_c]      = CACHE_S;
                    channel2_4_nxt[cli_c] = MSG_EMPTY;
                end
            end
            G_RECV_GNTE: begin
                if (channel2_4_reg[cli_c] == MSG_GNTE) begin
                    cache_nxt[cli_c]      = CACHE_E;
                    channel2_4_nxt[cli_c] = MSG_EMPTY;
                end
            end
            default: ;
        endcase
    end

    // Coherence invariant: an E copy excludes all others; an S copy excludes any E
    always_comb begin
        coherent_c = 1'b1;
        for (int i = 0; i < N_CLIENTS; i++) begin
            for (int j = 0; j < N_CLIENTS; j++) begin
                if (i != j) begin
                    if (cache_reg[i] == CACHE_E && cache_reg[j] != CACHE_I)
                        coherent_c = 1'b0;
                    if (cache_reg[i] == CACHE_S && cache_reg[j] == CACHE_E)
                        coherent_c = 1'b0;
                end
            end
        end
    end

    a_coherent: assert property (@(posedge clock) disable iff (reset) coherent_c);

endmodule

// File: tb/tb_cache_system.sv
// Directed bench for cache_system: observes protocol state hierarchically.
module tb_cache_system;

    logic       clock;
    logic       reset;
    logic [4:0] io_en_a;

    int n_cmp;
    int n_bad;

    cache_system dut (
        .clock   (clock),
        .reset   (reset),
        .io_en_a (io_en_a)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-state snapshot; zero means every field holds its reset value
    function automatic logic [63:0] snap();
        return 64'({dut.cache_reg[2], dut.cache_reg[1], dut.cache_reg[0],
                    dut.channel1_reg[2], dut.channel1_reg[1], dut.channel1_reg[0],
                    dut.channel2_4_reg[2], dut.channel2_4_reg[1], dut.channel2_4_reg[0],
                    dut.channel3_reg[2], dut.channel3_reg[1], dut.channel3_reg[0],
                    dut.home_sharer_list_reg, dut.home_invalidate_list_reg,
                    dut.home_current_command_reg, dut.home_current_client_reg,
                    dut.home_exclusive_granted_reg});
    endfunction

    function automatic logic [63:0] chans();
        return 64'({dut.channel1_reg[2], dut.channel1_reg[1], dut.channel1_reg[0],
                    dut.channel2_4_reg[2], dut.channel2_4_reg[1], dut.channel2_4_reg[0],
                    dut.channel3_reg[2], dut.channel3_reg[1], dut.channel3_reg[0]});
    endfunction

    function automatic logic coherent();
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (i != j) begin
                    if (dut.cache_reg[i] == 2'd2 && dut.cache_reg[j] != 2'd0) ok = 1'b0;
                    if (dut.cache_reg[i] == 2'd1 && dut.cache_reg[j] == 2'd2) ok = 1'b0;
                end
            end
        end
        return ok;
    endfunction

    task automatic do_reset();
        reset   = 1'b1;
        io_en_a = 5'd30;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic fire(input logic [4:0] k);
        io_en_a = k;
        @(posedge clock);
        #1;
        io_en_a = 5'd30;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset   = 1'b1;
        io_en_a = 5'd30;

        // Reset state
        do_reset();
        check("reset_snap", snap(), 64'd0);
        fire(5'd30);
        check("noop30_snap", snap(), 64'd0);

        // Client 0 obtains S
        fire(5'd0); fire(5'd6); fire(5'd18); fire(5'd24);
        check("s0_cache0", 64'(dut.cache_reg[0]), 64'd1);
        check("s0_sharer0", 64'(dut.home_sharer_list_reg[0]), 64'd1);
        check("s0_cmd", 64'(dut.home_current_command_reg), 64'd0);
        check("s0_chans", chans(), 64'd0);
        fire(5'd31);
        check("noop31_cache0", 64'(dut.cache_reg[0]), 64'd1);
        check("noop31_sharers", 64'(dut.home_sharer_list_reg), 64'd1);

        // Client 1 obtains E
        do_reset();
        fire(5'd4); fire(5'd7); fire(5'd22); fire(5'd28);
        check("e1_cache1", 64'(dut.cache_reg[1]), 64'd2);
        check("e1_exgntd", 64'(dut.home_exclusive_granted_reg), 64'd1);
        check("e1_sharer1", 64'(dut.home_sharer_list_reg[1]), 64'd1);
        check("e1_client", 64'(dut.home_current_client_reg), 64'd1);
        check("e1_chans", chans(), 64'd0);

        // Client 0 holds E, then client 2 requests S and forces an invalidate
        do_reset();
        fire(5'd3); fire(5'd6); fire(5'd21); fire(5'd27);
        check("e0_cache0", 64'(dut.cache_reg[0]), 64'd2);
        fire(5'd2); fire(5'd8); fire(5'd9);
        check("inv_ch2_0", 64'(dut.channel2_4_reg[0]), 64'd3);
        check("inv_list", 64'(dut.home_invalidate_list_reg), 64'd0);
        fire(5'd12);
        check("ack_ch3_0", 64'(dut.channel3_reg[0]), 64'd4);
        fire(5'd15); fire(5'd20); fire(5'd26);
        check("s2_cache0", 64'(dut.cache_reg[0]), 64'd0);
        check("s2_cache2", 64'(dut.cache_reg[2]), 64'd1);
        check("s2_exgntd", 64'(dut.home_exclusive_granted_reg), 64'd0);
        check("s2_sharers", 64'(dut.home_sharer_list_reg), 64'b100);
        check("s2_cmd", 64'(dut.home_current_command_reg), 64'd0);
        check("s2_chans", chans(), 64'd0);

        // A blocked grant: exclusive request while a sharer exists must wait
        fire(5'd4); fire(5'd7); fire(5'd22);
        check("blk_gnte_ch2_1", 64'(dut.channel2_4_reg[1]), 64'd0);
        check("blk_gnte_cmd", 64'(dut.home_current_command_reg), 64'd2);

        // False guards leave reset state untouched
        do_reset();
        fire(5'd24);
        check("gf_recvgnts", snap(), 64'd0);
        fire(5'd9);
        check("gf_sendinv", snap(), 64'd0);

        // Random sweep with a mid-run reset
        for (int c = 0; c < 200; c++) begin
            if (c == 100) begin
                do_reset();
                check("mid_reset_snap", snap(), 64'd0);
            end else begin
                fire(5'($urandom_range(31, 0)));
                check("rand_coherent", 64'(coherent()), 64'd1);
            end
        end
        do_reset();
        check("final_reset_snap", snap(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
